// File: rtl/popcount_seq.sv
// Multi-cycle population counter: accepts a W-bit word, sums G bits per cycle
// (ones, or zeros when mode=1) and returns the count over a valid/ready handshake.
module popcount_seq #(
    parameter int W = 32,
    parameter int G = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           din,
    input  logic                   mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(W+1)-1:0] count,
    output logic                   busy
);
    localparam int CW = $clog2(W + 1);
    localparam int N  = W / G;
    localparam int GW = $clog2(G + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if (G < 1 || G > W || (W % G) != 0) begin : g_param_check
        $error("popcount_seq: G must lie in 1..W and divide W evenly");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [W-1:0]  r_shreg;
    logic [W-1:0]  w_shreg_next;
    logic [CW-1:0] r_acc;
    logic [CW-1:0] w_acc_next;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_next;

    // Ones in the low group of the shift register; synthesis rebalances the chain.
    logic [GW-1:0] w_grp_part [G+1];
    assign w_grp_part[0] = '0;
    for (genvar gi = 0; gi < G; gi++) begin : g_grp_sum
        assign w_grp_part[gi+1] = w_grp_part[gi] + GW'(r_shreg[gi]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_shreg <= w_shreg_next;
            r_acc   <= w_acc_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shreg_next = r_shreg;
        w_acc_next   = r_acc;
        w_idx_next   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    // Zero counting becomes one counting on the inverted word.
                    w_shreg_next = mode ? ~din : din;
                    w_acc_next   = '0;
                    w_idx_next   = '0;
                    w_state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                w_acc_next   = r_acc + CW'(w_grp_part[G]);
                w_shreg_next = r_shreg >> G;
                w_idx_next   = r_idx + IW'(1);
                if (r_idx == IW'(N - 1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign count     = r_acc;

endmodule

// File: tb/tb_popcount_seq.sv
// Scoreboard bench for popcount_seq: directed and random words on a W=32,G=4
// instance plus random sweeps over several (W,G) instances.
module tb_popcount_seq;
    localparam int W  = 32;
    localparam int G  = 4;
    localparam int N  = W / G;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  din;
    logic          mode;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_cnt_q[$];
    int exp_cyc_q[$];
    bit seen_valid = 0;

    popcount_seq #(.W(W), .G(G)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Main-instance monitor: latency on first out_valid, count on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_valid = 0;
        end else if (out_valid) begin
            if (!seen_valid) begin
                seen_valid = 1;
                if (exp_cnt_q.size() == 0) chk("unexpected_out", 1, 0);
                else chk("latency", cyc - exp_cyc_q[0], N);
            end
            if (out_ready) begin
                seen_valid = 0;
                if (exp_cnt_q.size() != 0) begin
                    chk("count", int'(count), exp_cnt_q[0]);
                    $display("txn: count=%0d expected=%0d", count, exp_cnt_q[0]);
                    void'(exp_cnt_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
    task automatic send(input logic [W-1:0] d, input logic m, input bit toggle);
        int wc;
        wc = 0;
        in_valid = 1;
        din = d;
        mode = m;
        do begin
            @(negedge clk);
            wc++;
        end while (!in_ready && wc < 200);
        chk("accept", int'(in_ready), 1);
        exp_cnt_q.push_back($countones(m ? ~d : d));
        exp_cyc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        if (toggle) begin
            din = $urandom;
            mode = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_idle(input bit rnd);
        int c;
        c = 0;
        while (exp_cnt_q.size() != 0 && c < 1000) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            c++;
        end
        chk("drain", exp_cnt_q.size(), 0);
        out_ready = 1;
    endtask

    // Parameter sweep: each instance has its own driver, scoreboard and monitor.
    localparam int SW_W [4] = '{32, 32, 16, 8};
    localparam int SW_G [4] = '{1, 32, 4, 2};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
        localparam int WW  = SW_W[gi];
        localparam int GG  = SW_G[gi];
        localparam int NN  = WW / GG;
        localparam int CWW = $clog2(WW + 1);

        logic           s_rst_n = 0;
        logic           s_in_valid = 0;
        logic           s_in_ready;
        logic [WW-1:0]  s_din = '0;
        logic           s_mode = 0;
        logic           s_out_valid;
        logic           s_out_ready = 0;
        logic [CWW-1:0] s_count;
        logic           s_busy;
        int             q_cnt[$];
        int             q_cyc[$];
        bit             s_seen = 0;
        bit             done = 0;

        popcount_seq #(.W(WW), .G(GG)) u_dut (
            .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
            .din(s_din), .mode(s_mode), .out_valid(s_out_valid), .out_ready(s_out_ready),
            .count(s_count), .busy(s_busy)
        );

        always @(posedge clk) begin
            #1;
            s_out_ready = ($urandom_range(0, 3) != 0);
        end

        initial begin
            logic [WW-1:0] d;
            logic          m;
            int            wc;
            repeat (2) @(posedge clk);
            #1;
            s_rst_n = 1;
            for (int k = 0; k < 1000; k++) begin
                d = WW'($urandom);
                m = 1'($urandom_range(0, 1));
                s_din = d;
                s_mode = m;
                s_in_valid = 1;
                wc = 0;
                do begin
                    @(negedge clk);
                    wc++;
                end while (!s_in_ready && wc < 1000);
                if (!s_in_ready) begin
                    chk($sformatf("sw%0d_accept", gi), 0, 1);
                    break;
                end
                q_cnt.push_back($countones(m ? ~d : d));
                q_cyc.push_back(cyc + 1);
                @(posedge clk);
                #1;
                s_in_valid = 0;
                s_din = WW'($urandom);
            end
            wc = 0;
            while (q_cnt.size() != 0 && wc < 1000) begin
                @(posedge clk);
                wc++;
            end
            chk($sformatf("sw%0d_drain", gi), q_cnt.size(), 0);
            done = 1;
        end

        always @(negedge clk) begin
            if (s_rst_n && s_out_valid) begin
                if (!s_seen) begin
                    s_seen = 1;
                    if (q_cnt.size() == 0) chk($sformatf("sw%0d_unexpected", gi), 1, 0);
                    else chk($sformatf("sw%0d_latency", gi), cyc - q_cyc[0], NN);
                end
                if (s_out_ready) begin
                    s_seen = 0;
                    if (q_cnt.size() != 0) begin
                        chk($sformatf("sw%0d_count(W=%0d,G=%0d)", gi, WW, GG),
                            int'(s_count), q_cnt[0]);
                        void'(q_cnt.pop_front());
                        void'(q_cyc.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int c;
        int bad;
        rst_n = 0;
        in_valid = 0;
        din = '0;
        mode = 0;
        out_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        @(posedge clk);
        #1;
        rst_n = 1;

        // All ones: busy through the whole count, out_valid after N edges.
        send(32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("ready_drop", int'(in_ready), 0);
        chk("busy_rise", int'(busy), 1);
        bad = 0;
        repeat (N - 1) begin
            @(posedge clk);
            #1;
            if (!busy || out_valid || in_ready) bad++;
        end
        chk("count_phase", bad, 0);
        @(posedge clk);
        #1;
        chk("done_valid", int'(out_valid), 1);
        chk("done_busy", int'(busy), 1);
        wait_idle(1'b0);

        send(32'h0000_0000, 1'b1, 1'b0); wait_idle(1'b0);
        send(32'h0000_0000, 1'b0, 1'b0); wait_idle(1'b0);
        send(32'h8000_0001, 1'b0, 1'b0); wait_idle(1'b0);
        send(32'hF0F0_F0F0, 1'b0, 1'b0); wait_idle(1'b0);

        // Backpressure with a competing input word.
        out_ready = 0;
        send(32'hA5A5_A5A5, 1'b0, 1'b0);
        c = 0;
        while (!out_valid && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("bp_valid", int'(out_valid), 1);
        in_valid = 1;
        din = $urandom;
        mode = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_count", int'(count), 16);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_ready_back", int'(in_ready), 1);
        chk("bp_not_accepted", int'(busy), 0);
        chk("bp_valid_drop", int'(out_valid), 0);
        in_valid = 0;
        @(posedge clk);
        #1;

        // Reset on the third COUNT edge discards the word.
        send($urandom, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 0;
        exp_cnt_q.delete();
        exp_cyc_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1;
        bad = 0;
        repeat (N + 2) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("mid_rst_no_pulse", bad, 0);
        @(posedge clk);
        #1;
        send(32'h0000_00FF, 1'b0, 1'b0);
        wait_idle(1'b0);

        // Random words, din/mode scrambled after acceptance, random out_ready.
        for (int k = 0; k < 30; k++) begin
            send($urandom, 1'($urandom_range(0, 1)), 1'b1);
            wait_idle(1'b1);
        end

        c = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done)
               && c < 60000) begin
            @(posedge clk);
            c++;
        end
        chk("sweep_done", int'(g_sweep[0].done && g_sweep[1].done &&
                               g_sweep[2].done && g_sweep[3].done), 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
